data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised data memory for the CPU datapath: byte-addressed, big-endian, byte/half/word
//  loads and stores, sign/zero extension on loads, and a Req/Busy/Done handshake with a
//  configurable read latency so a multicycle or pipelined core can stall on it. Alignment
//  and range errors are reported per access. It replaces the fixed word-only data memory.
// PARAMETERS
//  DEPTH_BYTES  128  memory size in bytes, power of two, >= 4
//  ADDR_W       32   width of DAddr
//  RD_LAT       1    read latency in cycles, legal range 1..4
// PORTS
//  CLK       in   1       clock, all state changes on rising edge
//  Reset     in   1       asynchronous, active-high reset
//  Req       in   1       access request, sampled on rising edge of CLK
//  Busy      out  1       1 = request not accepted this edge
//  RD        in   1       0 = read access (active-low)
//  WR        in   1       0 = write access (active-low)
//  Size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  Signed    in   1       1 = sign-extend byte/half loads, 0 = zero-extend
//  DAddr     in   ADDR_W  byte address
//  DataIn    in   32      store data, right-justified for byte/half
//  DataOut   out  32      load result, valid while Done=1, held until the next read Done
//  Done      out  1       one-cycle completion pulse
//  Err       out  1       valid with Done: access was rejected
// BEHAVIOUR
//  - Reset: all memory bytes = 0; state IDLE; DataOut=0, Done=0, Err=0, Busy=0.
//  - Accept: edge with Req=1 and Busy=0. RD/WR/Size/Signed/DAddr/DataIn are captured on this edge.
//  - Opcode: exactly one of RD, WR low. RD=WR=0 or RD=WR=1 with Req=1 -> error access.
//  - Error access: Size=11, misaligned (half with DAddr[0]=1, word with DAddr[1:0]!=0), or DAddr>=DEPTH_BYTES.
//    An error access performs no write and leaves DataOut unchanged.
//    It completes like a write: Done=1, Err=1 in the cycle after the accept edge.
//  - Write: memory updated on the accept edge.
//    Big-endian layout: word -> mem[a]=DataIn[31:24] .. mem[a+3]=DataIn[7:0];
//    half -> mem[a]=DataIn[15:8], mem[a+1]=DataIn[7:0]; byte -> mem[a]=DataIn[7:0].
//    Done=1, Err=0 in the cycle after the accept edge.
//  - Read: Done=1, DataOut valid after edge N+RD_LAT-1, where N is the accept edge.
//    Byte/half is right-justified, extended per Signed. Word is mem[a..a+3] big-endian.
//  - FSM: IDLE -> (accept read, RD_LAT>1) WAIT; IDLE -> (any other accept) DONE.
//    WAIT counts RD_LAT-1 cycles -> DONE. DONE -> same accept rules as IDLE, else IDLE.
//  - Busy = (state==WAIT). A Req while Busy is ignored, not queued; the requester must hold it.
//  - Back-to-back: with RD_LAT=1, one access is accepted every cycle; Done stays high continuously.
//  - Read after write to the same address in the next accept returns the new data.
//  - Reset mid-WAIT: the read is aborted, no Done is produced, and memory is cleared.
//  - Address bits above log2(DEPTH_BYTES) are only used for the range check, never aliased.
// TESTING
//  1. Reset, then read word @0 -> Done after 1 cycle, DataOut=0x00000000, Err=0.
//  2. Write word 0x11223344 @8, then read word @8 -> 0x11223344.
//     Read byte @9 Signed=1 -> 0x00000022. Read half @10 -> 0x00003344.
//  3. Write byte 0xF0 @11, then read byte @11 Signed=1 -> 0xFFFFFFF0; Signed=0 -> 0x000000F0.
//     Read word @8 -> 0x112233F0.
//  4. Error cases, each -> Done=1, Err=1, mem[8..11] unchanged, DataOut unchanged:
//     write word @10; read half @9; Size=11; DAddr=DEPTH_BYTES; RD=WR=0.
//  5. RD_LAT=3: read @8 accepted at edge N -> Busy=1 for 2 cycles, Done at N+2.
//     A second Req during Busy is ignored. Back-to-back writes with RD_LAT=1 -> Done every cycle.
//  6. RD_LAT=3: assert Reset during WAIT -> no Done; after release, read @8 -> 0x00000000.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a CPU core and the data memory
//   master drives req, rd_n, wr_n, size, sgn, addr, wdata; slave returns busy, rdata, done, err
interface data_mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              busy;
   logic              rd_n;
   logic              wr_n;
   logic [1:0]        size;
   logic              sgn;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              done;
   logic              err;
   modport master (output req, rd_n, wr_n, size, sgn, addr, wdata, input busy, rdata, done, err);
   modport slave  (input req, rd_n, wr_n, size, sgn, addr, wdata, output busy, rdata, done, err);
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed big-endian data memory with byte/half/word access and a
//   req/busy/done handshake with configurable read latency
//   clk_i, rst_i (async, active-high); bus: data_mem_ctrl_if.slave
module data_mem_ctrl #(
   parameter int DEPTH_BYTES = 128,
   parameter int ADDR_W      = 32,
   parameter int RD_LAT      = 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   data_mem_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH_BYTES);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t        state_q;
   logic [7:0]    mem_q [DEPTH_BYTES];
   logic [1:0]    cnt_q;
   logic [AW-1:0] a_q;
   logic [1:0]    size_q;
   logic          sgn_q;
   logic [31:0]   rdata_q;
   logic          done_q;
   logic          err_q;
   logic [AW-1:0] idx;
   logic          rd_op;
   logic          bad;
   logic [AW-1:0] la;
   logic [1:0]    lsz;
   logic          lsg;
   logic [7:0]    b0, b1, b2, b3;
   logic [31:0]   ld_d;
   assign idx   = bus.addr[AW-1:0];
   assign rd_op = ~bus.rd_n & bus.wr_n;
   // Upper address bits only feed the range check, so out-of-range never aliases.
   assign bad = (bus.rd_n == bus.wr_n) | (bus.size == 2'b11)
              | ((bus.size == 2'b01) & bus.addr[0])
              | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00))
              | ({1'b0, bus.addr} >= (ADDR_W+1)'(DEPTH_BYTES));
   // Load path reads the live request on accept, or the captured one when leaving WAIT.
   always_comb begin
      la   = (state_q == WAIT) ? a_q : idx;
      lsz  = (state_q == WAIT) ? size_q : bus.size;
      lsg  = (state_q == WAIT) ? sgn_q : bus.sgn;
      b0   = mem_q[la];
      b1   = mem_q[la + AW'(1)];
      b2   = mem_q[la + AW'(2)];
      b3   = mem_q[la + AW'(3)];
      ld_d = (lsz == 2'b00) ? {{24{lsg & b0[7]}}, b0}
           : (lsz == 2'b01) ? {{16{lsg & b0[7]}}, b0, b1}
           : {b0, b1, b2, b3};
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         size_q  <= '0;
         sgn_q   <= 1'b0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (state_q == WAIT) begin
            if (cnt_q == '0) begin
               state_q <= DONE;
               done_q  <= 1'b1;
               rdata_q <= ld_d;
            end else begin
               cnt_q <= cnt_q - 2'd1;
            end
         end else if (bus.req) begin
            a_q    <= idx;
            size_q <= bus.size;
            sgn_q  <= bus.sgn;
            if (bad) begin
               state_q <= DONE;
               done_q  <= 1'b1;
               err_q   <= 1'b1;
            end else if (rd_op) begin
               if (RD_LAT > 1) begin
                  state_q <= WAIT;
                  cnt_q   <= 2'(RD_LAT - 2);
               end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  rdata_q <= ld_d;
               end
            end else begin
               state_q <= DONE;
               done_q  <= 1'b1;
               case (bus.size)
                  2'b00: mem_q[idx] <= bus.wdata[7:0];
                  2'b01: begin
                     mem_q[idx]          <= bus.wdata[15:8];
                     mem_q[idx + AW'(1)] <= bus.wdata[7:0];
                  end
                  default: begin
                     mem_q[idx]          <= bus.wdata[31:24];
                     mem_q[idx + AW'(1)] <= bus.wdata[23:16];
                     mem_q[idx + AW'(2)] <= bus.wdata[15:8];
                     mem_q[idx + AW'(3)] <= bus.wdata[7:0];
                  end
               endcase
            end
         end else begin
            state_q <= IDLE;
         end
      end
   end
   assign bus.busy  = (state_q == WAIT);
   assign bus.rdata = rdata_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl with read latency 1 and 3
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req1 = 1'b0, req3 = 1'b0;
   logic        rd_n = 1'b1, wr_n = 1'b1, sgn = 1'b0;
   logic [1:0]  size = 2'b10;
   logic [31:0] addr = '0, wdata = '0;
   int          n_cmp = 0, n_bad = 0;
   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;
   data_mem_ctrl_if #(.ADDR_W(32)) if1 ();
   data_mem_ctrl_if #(.ADDR_W(32)) if3 ();
   assign if1.req = req1;
   assign if3.req = req3;
   assign if1.rd_n = rd_n;   assign if3.rd_n = rd_n;
   assign if1.wr_n = wr_n;   assign if3.wr_n = wr_n;
   assign if1.size = size;   assign if3.size = size;
   assign if1.sgn = sgn;     assign if3.sgn = sgn;
   assign if1.addr = addr;   assign if3.addr = addr;
   assign if1.wdata = wdata; assign if3.wdata = wdata;
   data_mem_ctrl #(.DEPTH_BYTES(128), .ADDR_W(32), .RD_LAT(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
   data_mem_ctrl #(.DEPTH_BYTES(128), .ADDR_W(32), .RD_LAT(3)) u3 (.clk_i(clk), .rst_i(rst), .bus(if3.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic setv(input logic rn, input logic wn, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
      rd_n = rn; wr_n = wn; size = sz; sgn = sg; addr = ad; wdata = wd;
   endtask
   // One access on the latency-1 instance; outputs are sampled 1 time unit after the accept edge.
   task automatic acc1(input logic rn, input logic wn, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
      setv(rn, wn, sz, sg, ad, wd);
      req1 = 1'b1;
      @(posedge clk); #1;
      req1 = 1'b0;
   endtask
   task automatic rd1(input string tag, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] exp);
      acc1(1'b0, 1'b1, sz, sg, ad, 32'h0);
      chk({tag, "_done"}, if1.done, 1);
      chk({tag, "_err"}, if1.err, 0);
      chk({tag, "_data"}, if1.rdata, exp);
   endtask
   task automatic err1(input string tag, input logic rn, input logic wn, input logic [1:0] sz,
                       input logic [31:0] ad, input logic [31:0] wd);
      acc1(rn, wn, sz, 1'b0, ad, wd);
      chk({tag, "_done"}, if1.done, 1);
      chk({tag, "_err"}, if1.err, 1);
      chk({tag, "_hold"}, if1.rdata, 32'h112233F0);
   endtask
   task automatic rd3(input string tag, input logic [31:0] ad, input logic [31:0] exp);
      setv(1'b0, 1'b1, W, 1'b0, ad, 32'h0);
      req3 = 1'b1;
      @(posedge clk); #1;
      req3 = 1'b0;
      for (int i = 0; i < 8 && !if3.done; i++) begin
         @(posedge clk); #1;
      end
      chk({tag, "_done"}, if3.done, 1);
      chk({tag, "_data"}, if3.rdata, exp);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_done", if1.done, 0);
      chk("rst_err", if1.err, 0);
      chk("rst_busy", if1.busy, 0);
      chk("rst_data", if1.rdata, 0);
      chk("rst_busy3", if3.busy, 0);
      rd1("rd0", W, 1'b0, 0, 32'h0);
      acc1(1'b1, 1'b0, W, 1'b0, 8, 32'h11223344);
      chk("wr8_done", if1.done, 1);
      chk("wr8_err", if1.err, 0);
      rd1("rw8", W, 1'b0, 8, 32'h11223344);
      rd1("rb9s", B, 1'b1, 9, 32'h00000022);
      rd1("rh10", H, 1'b0, 10, 32'h00003344);
      acc1(1'b1, 1'b0, B, 1'b0, 11, 32'h000000F0);
      chk("wb11_done", if1.done, 1);
      rd1("rb11s", B, 1'b1, 11, 32'hFFFFFFF0);
      rd1("rb11u", B, 1'b0, 11, 32'h000000F0);
      rd1("rw8b", W, 1'b0, 8, 32'h112233F0);
      @(posedge clk); #1;
      chk("done_pulse", if1.done, 0);
      err1("e_wmis", 1'b1, 1'b0, W, 10, 32'hAAAAAAAA);
      err1("e_hmis", 1'b0, 1'b1, H, 9, 32'h0);
      err1("e_size", 1'b1, 1'b0, X, 8, 32'hCCCCCCCC);
      err1("e_range", 1'b0, 1'b1, W, 128, 32'h0);
      err1("e_alias", 1'b1, 1'b0, W, 136, 32'hBBBBBBBB);
      err1("e_rdwr0", 1'b0, 1'b0, W, 8, 32'h55555555);
      err1("e_rdwr1", 1'b1, 1'b1, W, 8, 32'h66666666);
      rd1("rw8c", W, 1'b0, 8, 32'h112233F0);
      // Back-to-back byte writes with req held high across three edges.
      setv(1'b1, 1'b0, B, 1'b0, 0, 32'hA1);
      req1 = 1'b1;
      @(posedge clk); #1;
      chk("b2b_0", if1.done, 1);
      setv(1'b1, 1'b0, B, 1'b0, 1, 32'hA2);
      @(posedge clk); #1;
      chk("b2b_1", if1.done, 1);
      setv(1'b1, 1'b0, B, 1'b0, 2, 32'hA3);
      @(posedge clk); #1;
      chk("b2b_2", if1.done, 1);
      setv(1'b0, 1'b1, W, 1'b0, 0, 32'h0);
      @(posedge clk); #1;
      req1 = 1'b0;
      chk("b2b_rd_done", if1.done, 1);
      chk("b2b_rd_data", if1.rdata, 32'hA1A2A300);
      // Latency-3 instance: write, then a read with a competing write held during busy.
      setv(1'b1, 1'b0, W, 1'b0, 8, 32'h11223344);
      req3 = 1'b1;
      @(posedge clk); #1;
      chk("l3_wr_done", if3.done, 1);
      setv(1'b0, 1'b1, W, 1'b0, 8, 32'h0);
      @(posedge clk); #1;
      chk("l3_busy_n", if3.busy, 1);
      chk("l3_nodone_n", if3.done, 0);
      setv(1'b1, 1'b0, W, 1'b0, 8, 32'hDEADBEEF);
      @(posedge clk); #1;
      chk("l3_busy_n1", if3.busy, 1);
      chk("l3_nodone_n1", if3.done, 0);
      @(posedge clk); #1;
      req3 = 1'b0;
      chk("l3_busy_n2", if3.busy, 0);
      chk("l3_done_n2", if3.done, 1);
      chk("l3_err_n2", if3.err, 0);
      chk("l3_data_n2", if3.rdata, 32'h11223344);
      @(posedge clk); #1;
      chk("l3_done_drop", if3.done, 0);
      rd3("l3_ign", 8, 32'h11223344);
      // Reset during WAIT aborts the read and clears memory.
      setv(1'b0, 1'b1, W, 1'b0, 8, 32'h0);
      req3 = 1'b1;
      @(posedge clk); #1;
      req3 = 1'b0;
      chk("l3_busy_pre", if3.busy, 1);
      rst = 1'b1;
      #1;
      chk("l3_rst_busy", if3.busy, 0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("l3_rst_nodone", if3.done, 0);
      end
      rst = 1'b0;
      rd3("l3_clr", 8, 32'h0);
      rd1("l1_clr", W, 1'b0, 8, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
